// File: rtl/debounce_chan.sv
// One debounce channel: accepts a new level only after STABLE consecutive
// sample ticks disagree with the current output, and pulses rise/fall on change.
module debounce_chan #(
  parameter int unsigned STABLE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = ($clog2(STABLE + 1) > 1) ? $clog2(STABLE + 1) : 1;

  logic [CW-1:0] cnt;

  // A tick that agrees with the current level restarts qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (din != dout) begin
          if (cnt == CW'(STABLE - 1)) begin
            dout <= din;
            cnt  <= '0;
            rise <= din;
            fall <= ~din;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: per-bit two-flop synchroniser, shared
// sample-tick prescaler and one debounce_chan per input.
module debounce_multi #(
  parameter int unsigned N_BTN  = 5,
  parameter int unsigned DIV    = 100000,
  parameter int unsigned STABLE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btnin,
  output logic [N_BTN-1:0] btnout,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall
);

  localparam int unsigned PW = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [PW-1:0]    pcnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btnin;
      s2 <= s1;
    end
  end

  // With DIV=1 the counter sits at 0 and tick stays high.
  assign tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_chan #(
      .STABLE(STABLE)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .din (s2[i]),
      .dout(btnout[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: two configurations (DIV=4/STABLE=3 and
// DIV=1/STABLE=1) against a tick-sampling reference model.
module tb_debounce_multi;

  localparam int unsigned NB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btnin_a = '0;
  logic [NB-1:0] btnin_b = '0;
  logic [NB-1:0] btnout_a, rise_a, fall_a;
  logic [NB-1:0] btnout_b, rise_b, fall_b;

  always #5 clk = ~clk;

  debounce_multi #(.N_BTN(NB), .DIV(4), .STABLE(3)) u_dut_a (
    .clk(clk), .rst(rst), .btnin(btnin_a),
    .btnout(btnout_a), .rise(rise_a), .fall(fall_a)
  );

  debounce_multi #(.N_BTN(NB), .DIV(1), .STABLE(1)) u_dut_b (
    .clk(clk), .rst(rst), .btnin(btnin_b),
    .btnout(btnout_b), .rise(rise_b), .fall(fall_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  // Reference model state, one slot per configuration.
  int            cfg_div[2]  = '{4, 1};
  int            cfg_stab[2] = '{3, 1};
  logic [NB-1:0] hist[2][$];
  int            since_rst[2];
  logic [NB-1:0] lvl[2];
  int            ndiff[2][NB];
  logic [3*NB-1:0] q_a[$];
  logic [3*NB-1:0] q_b[$];
  bit            armed = 1'b0;

  // Level seen by the debounce logic is the input sampled two clock edges earlier.
  task automatic model_step();
    logic [NB-1:0] seen;
    logic [NB-1:0] r, f;
    bit            tick;
    for (int c = 0; c < 2; c++) begin
      r = '0;
      f = '0;
      if (rst) begin
        hist[c].delete();
        since_rst[c] = 0;
        lvl[c] = '0;
        for (int i = 0; i < int'(NB); i++) ndiff[c][i] = 0;
      end else begin
        seen = (hist[c].size() >= 2) ? hist[c][hist[c].size()-2] : '0;
        tick = (since_rst[c] % cfg_div[c]) == (cfg_div[c] - 1);
        since_rst[c]++;
        hist[c].push_back(c == 0 ? btnin_a : btnin_b);
        if (hist[c].size() > 4) void'(hist[c].pop_front());
        if (tick) begin
          for (int i = 0; i < int'(NB); i++) begin
            if (seen[i] != lvl[c][i]) begin
              ndiff[c][i]++;
              if (ndiff[c][i] >= cfg_stab[c]) begin
                lvl[c][i] = seen[i];
                r[i] = seen[i];
                f[i] = ~seen[i];
                ndiff[c][i] = 0;
              end
            end else begin
              ndiff[c][i] = 0;
            end
          end
        end
      end
      if (c == 0) q_a.push_back({lvl[c], r, f});
      else        q_b.push_back({lvl[c], r, f});
    end
  endtask

  task automatic cyc(input logic r, input logic [NB-1:0] a, input logic [NB-1:0] b);
    @(posedge clk);
    model_step();
    cycle++;
    #1;
    rst     = r;
    btnin_a = a;
    btnin_b = b;
  endtask

  // Monitor: every cycle the DUT presents registered outputs; pop and compare.
  always @(negedge clk) begin
    logic [3*NB-1:0] exp_v;
    if (q_a.size() != 0 && q_b.size() != 0) begin
      armed = 1'b1;
      exp_v = q_a.pop_front();
      n_checks++;
      if ({btnout_a, rise_a, fall_a} === exp_v) n_pass++;
      else $display("FAIL cfgA cyc %0d: got btnout=%b rise=%b fall=%b, want btnout=%b rise=%b fall=%b",
                    cycle, btnout_a, rise_a, fall_a, exp_v[3*NB-1:2*NB], exp_v[2*NB-1:NB], exp_v[NB-1:0]);
      exp_v = q_b.pop_front();
      n_checks++;
      if ({btnout_b, rise_b, fall_b} === exp_v) n_pass++;
      else $display("FAIL cfgB cyc %0d: got btnout=%b rise=%b fall=%b, want btnout=%b rise=%b fall=%b",
                    cycle, btnout_b, rise_b, fall_b, exp_v[3*NB-1:2*NB], exp_v[2*NB-1:NB], exp_v[NB-1:0]);
    end else if (armed) begin
      n_checks++;
      $display("FAIL scoreboard cyc %0d: expected entry missing, got none, want one", cycle);
    end
  end

  logic [NB-1:0] va, vb;
  int            seg;
  bit            bouncy;

  initial begin
    cyc(1'b1, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00);
    // Clean press on channel 0, held from cycle 0.
    for (int c = 0; c < 20; c++) cyc(1'b0, 2'b01, (c % 5 == 0) ? 2'b10 : 2'b01);
    // Bounce: input low at cycle 9 spoils the tick-11 sample.
    cyc(1'b1, 2'b00, 2'b00);
    for (int c = 0; c < 40; c++) cyc(1'b0, (c == 9) ? 2'b00 : 2'b01, 2'(c));
    // Release.
    for (int c = 0; c < 30; c++) cyc(1'b0, 2'b00, 2'b11);
    // Simultaneous press then release on both channels.
    for (int c = 0; c < 30; c++) cyc(1'b0, 2'b11, 2'b00);
    for (int c = 0; c < 30; c++) cyc(1'b0, 2'b00, 2'b10);
    // Reset after two qualifying ticks, then a full qualification again.
    cyc(1'b1, 2'b00, 2'b00);
    for (int c = 0; c < 9; c++) cyc(1'b0, 2'b01, 2'b01);
    cyc(1'b1, 2'b01, 2'b01);
    for (int c = 0; c < 20; c++) cyc(1'b0, 2'b01, 2'b01);
    // Randomised segments: steady holds and bouncy stretches, occasional reset.
    va = 2'b00;
    vb = 2'b00;
    for (int s = 0; s < 120; s++) begin
      seg    = int'($urandom_range(4, 40));
      bouncy = ($urandom_range(0, 2) == 0);
      va     = 2'($urandom);
      vb     = 2'($urandom);
      for (int c = 0; c < seg; c++) begin
        if (bouncy && $urandom_range(0, 2) == 0) va = va ^ 2'($urandom);
        if (bouncy && $urandom_range(0, 2) == 0) vb = vb ^ 2'($urandom);
        cyc(($urandom_range(0, 199) == 0), va, vb);
      end
    end
    @(posedge clk);
    model_step();
    cycle++;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
